uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_arb_pkg.sv | 20 ++
 rtl/uart_rr_pick.sv | 31 +++
 rtl/uart_tx_arb.sv | 136 +++++++++++++
 tb/tb_uart_tx_arb.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encodings,
// default parameter values and a small index-wrap helper.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_START = 2'd1,
        ST_GUARD = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    localparam int DEFAULT_NUM_REQ      = 3;
    localparam int DEFAULT_LOCK_TIMEOUT = 1023;

    // Next requester index, wrapping at n (n is at most 4).
    function automatic logic [1:0] wrap_inc(input logic [1:0] idx, input int n);
        return (int'(idx) + 1 >= n) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of mask
// found by scanning upward from start, wrapping at NUM_REQ.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] mask,
    input  logic [1:0]         start,
    output logic [1:0]         idx,
    output logic               found
);

    logic [1:0] cand;

    // Scan all requesters once, starting at the start index, and keep the first hit.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
        idx   = start;
        found = 1'b0;
        cand  = start;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
            cand = wrap_inc(cand, NUM_REQ);
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding byte streams from NUM_REQ requesters into one
// UART transmitter, with per-message locking on req_last.
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to release a lock after
// LOCK_TIMEOUT consecutive idle ARB cycles; without it the lock is held
// until a last byte is accepted.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = DEFAULT_NUM_REQ,
    parameter int LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_accept,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [1:0]           grant_id,
    output logic                 locked
);

    arb_state_t         state;
    arb_state_t         state_next;
    logic               grant_go;
    logic               last_q;
    logic [1:0]         rr_ptr;
    logic [NUM_REQ-1:0] grant_mask;
    logic [NUM_REQ-1:0] pick_mask;
    logic [1:0]         pick_start;
    logic [1:0]         pick_idx;
    logic               pick_found;
    logic [7:0]         pick_data;
    logic               pick_last;
    logic               lock_expire;

    // While locked only the holder may win, and the scan starts at the holder.
    assign grant_mask = NUM_REQ'(1) << grant_id;
    assign pick_mask  = locked ? (req_valid & grant_mask) : req_valid;
    assign pick_start = locked ? grant_id : rr_ptr;

    uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .mask  (pick_mask),
        .start (pick_start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Select the byte and last flag of the requester the picker chose.
    always_comb begin
        pick_data = '0;
        pick_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == 2'(i)) begin
                pick_data = req_data[8*i +: 8];
                pick_last = req_last[i];
            end
        end
    end

    // The accept pulse coincides with tx_start and goes only to the granted requester.
    assign tx_start   = (state == ST_START);
    assign req_accept = tx_start ? grant_mask : '0;

    // Next-state logic: grant in ARB, fixed START/GUARD cycles, wait out tx_busy in DRAIN.
    always_comb begin
        state_next = state;
        grant_go   = 1'b0;
        case (state)
            ST_ARB: begin
                if (!tx_busy && pick_found) begin
                    grant_go   = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: state_next = ST_GUARD;
            ST_GUARD: state_next = ST_DRAIN;
            ST_DRAIN: if (!tx_busy) state_next = ST_ARB;
            default:  state_next = ST_ARB;
        endcase
    end

    // State register; reset drops any byte in flight back to ARB.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= ST_ARB;
        else     state <= state_next;
    end

    // Latch the granted byte, grant and pointer on the grant cycle; track the message lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data  <= 8'h00;
            grant_id <= 2'd0;
            last_q   <= 1'b0;
            rr_ptr   <= 2'd0;
            locked   <= 1'b0;
        end else begin
            if (grant_go) begin
                tx_data  <= pick_data;
                grant_id <= pick_idx;
                last_q   <= pick_last;
                rr_ptr   <= wrap_inc(pick_idx, NUM_REQ);
            end
            if (state == ST_START)
                locked <= ~last_q;
            else if (lock_expire)
                locked <= 1'b0;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    logic [CNT_W-1:0] idle_cnt;
    logic             idle_cycle;

    assign idle_cycle  = (state == ST_ARB) && locked && !(|(req_valid & grant_mask));
    assign lock_expire = idle_cycle && (idle_cnt == CNT_W'(LOCK_TIMEOUT - 1));

    // Count consecutive locked ARB cycles with the holder idle; clear on accept or activity.
    always_ff @(posedge clk) begin
        if (rst || state == ST_START || lock_expire)
            idle_cnt <= '0;
        else if (idle_cycle)
            idle_cnt <= idle_cnt + CNT_W'(1);
        else if (state == ST_ARB)
            idle_cnt <= '0;
    end
`else
    assign lock_expire = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: a vector table of single-byte
// arbitration rounds plus hand-written multi-cycle sequences, with a
// scoreboard of expected {grant, byte, lock} per tx_start.
module tb_uart_tx_arb;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_accept;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy = 1'b0;
    logic [1:0]     grant_id;
    logic           locked;

    uart_tx_arb #(.NUM_REQ(N), .LOCK_TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_accept (req_accept),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       lock_after;
    } exp_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } byte_t;

    typedef struct {
        logic [2:0]  valid;
        logic [23:0] data;
        logic [2:0]  last;
        int          busy;
        logic [1:0]  id;
        logic [7:0]  exp_data;
        logic        exp_lock;
    } vec_t;

    exp_t  sb[$];
    byte_t seq[N][4];
    int    seq_len[N];
    int    seq_pos[N];
    int    busy_cnt = 0;
    int    busy_len = 2;
    bit    force_busy = 1'b0;
    bit    lock_pending = 1'b0;
    logic  lock_exp = 1'b0;
    int    cycle = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    vec_t  vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (seq_pos[i] < seq_len[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = seq[i][seq_pos[i]].data;
                req_last[i]        = seq[i][seq_pos[i]].last;
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        tx_busy = force_busy || (busy_cnt > 0);
    endtask

    // One clock: sample at the falling edge, score tx_start, model the
    // transmitter busy time and advance requester streams on accept.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cycle++;
        if (busy_cnt > 0) busy_cnt--;
        if (!rst) begin
            if (lock_pending) begin
                check("locked_after_accept", 32'(locked), 32'(lock_exp));
                lock_pending = 1'b0;
            end
            if (tx_start) begin
                if (sb.size() == 0) begin
                    check("tx_start_unexpected", 32'(tx_start), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("grant_id", 32'(grant_id), 32'(e.id));
                    check("tx_data", 32'(tx_data), 32'(e.data));
                    check("req_accept", 32'(req_accept), 32'(3'b001 << e.id));
                    lock_pending = 1'b1;
                    lock_exp     = e.lock_after;
                end
                for (int i = 0; i < N; i++)
                    if (req_accept[i] && seq_pos[i] < seq_len[i]) seq_pos[i]++;
                if (!force_busy) busy_cnt = busy_len;
            end else if (req_accept != '0) begin
                check("accept_without_start", 32'(req_accept), 32'd0);
            end
        end
        drive_inputs();
    endtask

    task automatic wait_sb_empty(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            check(name, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic clear_streams();
        for (int i = 0; i < N; i++) begin
            seq_len[i] = 0;
            seq_pos[i] = 0;
        end
    endtask

    task automatic do_reset(input bit check_vals);
        rst          = 1'b1;
        sb.delete();
        lock_pending = 1'b0;
        busy_cnt     = 0;
        force_busy   = 1'b0;
        clear_streams();
        drive_inputs();
        tick();
        tick();
        if (check_vals) begin
            check("rst_tx_start", 32'(tx_start), 32'd0);
            check("rst_req_accept", 32'(req_accept), 32'd0);
            check("rst_tx_data", 32'(tx_data), 32'h00);
            check("rst_grant_id", 32'(grant_id), 32'd0);
            check("rst_locked", 32'(locked), 32'd0);
        end
        rst = 1'b0;
        drive_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;
        exp_t e;

        // valid, data {r2,r1,r0}, last, busy, exp grant, exp byte, exp lock
        vecs[0] = '{3'b001, 24'h000041, 3'b111, 10, 2'd0, 8'h41, 1'b0};
        vecs[1] = '{3'b111, 24'hC2B2A2, 3'b111,  2, 2'd1, 8'hB2, 1'b0};
        vecs[2] = '{3'b111, 24'hC3B3A3, 3'b111,  2, 2'd2, 8'hC3, 1'b0};
        vecs[3] = '{3'b101, 24'hC400A4, 3'b111,  2, 2'd0, 8'hA4, 1'b0};
        vecs[4] = '{3'b101, 24'hC500A5, 3'b111,  2, 2'd2, 8'hC5, 1'b0};
        vecs[5] = '{3'b010, 24'h00B600, 3'b101,  2, 2'd1, 8'hB6, 1'b1};
        vecs[6] = '{3'b111, 24'hC7B7A7, 3'b111,  2, 2'd1, 8'hB7, 1'b0};
        vecs[7] = '{3'b011, 24'h00B8A8, 3'b111,  2, 2'd0, 8'hA8, 1'b0};
        vecs[8] = '{3'b100, 24'hC90000, 3'b111,  0, 2'd2, 8'hC9, 1'b0};

        do_reset(1'b1);

        // Table: one byte per round; losers drop valid before the next grant.
        foreach (vecs[v]) begin
            busy_len = vecs[v].busy;
            clear_streams();
            for (int i = 0; i < N; i++) begin
                seq[i][0]  = '{vecs[v].data[8*i +: 8], vecs[v].last[i]};
                seq_len[i] = vecs[v].valid[i] ? 1 : 0;
            end
            sb.push_back('{vecs[v].id, vecs[v].exp_data, vecs[v].exp_lock});
            drive_inputs();
            wait_sb_empty("table_grant_timeout", 30);
            clear_streams();
            drive_inputs();
            repeat (vecs[v].busy + 4) tick();
        end

        // All three requesters continuously valid: strict 0,1,2 rotation.
        do_reset(1'b0);
        busy_len = 3;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 2; k++) seq[i][k] = '{{4'(i + 1), 4'(k)}, 1'b1};
            seq_len[i] = 2;
        end
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) begin
                e = '{2'(i), {4'(i + 1), 4'(k)}, 1'b0};
                sb.push_back(e);
            end
        drive_inputs();
        wait_sb_empty("rr_timeout", 100);
        check("rr_all_consumed", 32'(seq_pos[0] + seq_pos[1] + seq_pos[2]), 32'd6);

        // Two-byte message on req1 must not be interleaved.
        do_reset(1'b0);
        busy_len = 1;
        seq[0][0] = '{8'h40, 1'b1}; seq[0][1] = '{8'h41, 1'b1}; seq_len[0] = 2;
        seq[1][0] = '{8'h41, 1'b0}; seq[1][1] = '{8'h42, 1'b1}; seq_len[1] = 2;
        seq[2][0] = '{8'h50, 1'b1}; seq[2][1] = '{8'h51, 1'b1}; seq_len[2] = 2;
        sb.push_back('{2'd0, 8'h40, 1'b0});
        sb.push_back('{2'd1, 8'h41, 1'b1});
        sb.push_back('{2'd1, 8'h42, 1'b0});
        sb.push_back('{2'd2, 8'h50, 1'b0});
        sb.push_back('{2'd0, 8'h41, 1'b0});
        sb.push_back('{2'd2, 8'h51, 1'b0});
        drive_inputs();
        wait_sb_empty("lock_msg_timeout", 100);

        // Lock holder goes idle while another requester waits.
        do_reset(1'b0);
        busy_len = 0;
        seq[2][0] = '{8'hD2, 1'b0}; seq_len[2] = 1;
        sb.push_back('{2'd2, 8'hD2, 1'b1});
        drive_inputs();
        wait_sb_empty("lock_first_timeout", 20);
        t0 = cycle;
        seq[0][0] = '{8'hD0, 1'b1}; seq_len[0] = 1;
        sb.push_back('{2'd0, 8'hD0, 1'b0});
        drive_inputs();
`ifdef UART_TX_ARB_TIMEOUT_EN
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
            if (cycle - t0 == 10) check("lock_held_before_timeout", 32'(locked), 32'd1);
            if (cycle - t0 == 11) check("lock_released_by_timeout", 32'(locked), 32'd0);
        end
        check("timeout_grant_delay", 32'(cycle - t0), 32'd12);
        sb.delete();
`else
        repeat (40) tick();
        check("lock_held_no_grant", 32'(sb.size()), 32'd1);
        check("lock_held_locked", 32'(locked), 32'd1);
        seq[2][1] = '{8'hE2, 1'b1}; seq_len[2] = 2;
        sb.push_front('{2'd2, 8'hE2, 1'b0});
        drive_inputs();
        wait_sb_empty("lock_end_timeout", 40);
`endif

        // Externally held tx_busy blocks the grant.
        do_reset(1'b0);
        busy_len   = 2;
        force_busy = 1'b1;
        seq[0][0] = '{8'h33, 1'b1}; seq_len[0] = 1;
        sb.push_back('{2'd0, 8'h33, 1'b0});
        drive_inputs();
        repeat (10) tick();
        check("busy_holds_off_start", 32'(sb.size()), 32'd1);
        force_busy = 1'b0;
        drive_inputs();
        tick();
        tick();
        check("start_within_2_after_busy", 32'(sb.size()), 32'd0);
        sb.delete();
        repeat (4) tick();

        // Reset during DRAIN: no repeat of the aborted byte, restart at index 0.
        busy_len = 10;
        clear_streams();
        seq[0][0] = '{8'h70, 1'b1}; seq_len[0] = 1;
        seq[1][0] = '{8'h71, 1'b1}; seq[1][1] = '{8'h72, 1'b1}; seq_len[1] = 2;
        sb.push_back('{2'd1, 8'h71, 1'b0});
        drive_inputs();
        wait_sb_empty("pre_reset_timeout", 20);
        repeat (3) tick();
        rst = 1'b1;
        drive_inputs();
        tick();
        check("mid_rst_tx_start", 32'(tx_start), 32'd0);
        check("mid_rst_req_accept", 32'(req_accept), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'h00);
        check("mid_rst_grant_id", 32'(grant_id), 32'd0);
        check("mid_rst_locked", 32'(locked), 32'd0);
        rst          = 1'b0;
        busy_cnt     = 0;
        lock_pending = 1'b0;
        sb.delete();
        sb.push_back('{2'd0, 8'h70, 1'b0});
        sb.push_back('{2'd1, 8'h72, 1'b0});
        drive_inputs();
        wait_sb_empty("post_reset_timeout", 60);
        repeat (15) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
